fifo_frame_writer: RTL and testbench
====================================

Name: fifo_frame_writer

Overview:
- Write-side producer for the team's dual-clock FIFO, running entirely in the wclk domain.
- Collects a frame from an upstream valid/ready stream into a local buffer.
- Then pushes a length header word followed by the payload words into the FIFO write port, honouring fifo_full.
- Gives the read-side consumer a self-delimiting framed word stream.

Parameters:
- DWIDTH, 8, data word width; must match the FIFO data width.
- MAX_LEN, 16, maximum payload words per frame; power of 2; must be at most 2^DWIDTH-1.

Ports:
- wclk  input  1  write-domain clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- s_valid  input  1  upstream word valid.
- s_data  input  DWIDTH  upstream word.
- s_last  input  1  marks the final word of a frame.
- s_ready  output  1  block can accept an upstream word.
- push  output  1  FIFO write strobe.
- din  output  DWIDTH  FIFO write data.
- fifo_full  input  1  FIFO full flag (wclk domain).
- frame_done  output  1  one-cycle pulse after the last payload word of a frame is pushed.
- frame_err  output  1  one-cycle pulse when an oversize frame is dropped.
- frame_cnt  output  16  count of frames fully pushed; wraps from 0xFFFF to 0.
- busy  output  1  high in any state other than COLLECT.

Behaviour:
- Reset (async, rstn=0):
  - state=COLLECT; write index, read index and length cleared.
  - s_ready=1 once released; push=0, frame_done=0, frame_err=0, frame_cnt=0, busy=0.
  - Buffer contents are don't-care.
  - Reset mid-frame discards the partial frame; push drops to 0 immediately (combinational from state).
- Upstream handshake: a word is accepted on a rising edge with s_valid & s_ready. s_data/s_last are sampled only then.
- FIFO handshake: a word is written when push & ~fifo_full. push is only driven when ~fifo_full, so every push cycle is a completed write.
- FSM states: COLLECT, DROP, HDR, PAYLOAD.
- COLLECT:
  - s_ready=1. Each accepted word is written to buf[wr_idx] and wr_idx increments.
  - Accepted with s_last=1: len=wr_idx+1, go to HDR.
  - Accepted with s_last=0 while wr_idx==MAX_LEN-1 (buffer full, no last): go to DROP. Nothing of this frame is pushed.
- DROP:
  - s_ready=1; words are consumed and discarded.
  - On accepted s_last=1: pulse frame_err next cycle, clear indices, go to COLLECT.
  - A frame of exactly MAX_LEN words ending with s_last is legal and is not dropped.
- HDR:
  - s_ready=0. push=~fifo_full; din=len, zero-extended to DWIDTH (range 1..MAX_LEN).
  - On a push, go to PAYLOAD with rd_idx=0.
  - While fifo_full=1: hold state, push=0, din stable.
- PAYLOAD:
  - s_ready=0. push=~fifo_full; din=buf[rd_idx].
  - Each push increments rd_idx.
  - A push with rd_idx==len-1 completes the frame:
    - frame_done pulses the next cycle and frame_cnt increments in the same cycle.
    - Indices clear and state returns to COLLECT, so s_ready=1 the next cycle.
  - fifo_full stalls: hold rd_idx and din.
- Timing with no backpressure:
  - N-word frame accepted over N cycles (or more if s_valid gaps).
  - Header pushed in cycle 1 after the last accept; payload words pushed in cycles 2..N+1; frame_done in cycle N+2.
  - Throughput: N accepts plus N+1 pushes per frame, no overlap.
- Zero-length frames cannot occur (s_last always rides a data word).
- Index widths: clog2(MAX_LEN)+1 bits to hold len=MAX_LEN; no wrap within a frame.
- frame_done and frame_err are registered and never high simultaneously.

Test Plan:
- Reset mid-PAYLOAD (assert rstn during the 2nd payload push of a 4-word frame) -> push=0 immediately, frame_cnt=0, s_ready=1 after release; the next frame 0xAA (single word) pushes 0x01,0xAA.
- Single frame 0x11,0x22,0x33 (s_last on 0x33), fifo_full=0 -> push high 4 consecutive cycles with din=0x03,0x11,0x22,0x33; frame_done 1 cycle later; frame_cnt=1; s_ready=0 throughout the pushes.
- Same frame with fifo_full=1 for 5 cycles at the header and 2 cycles before 0x22 -> no push while full, din held, same 4-word sequence, no loss or duplication.
- MAX_LEN=16 frame of exactly 16 words (0x00..0x0F, last on 0x0F) -> header 0x10 then the 16 words; frame_err=0.
- Oversize frame of 20 words, then legal frame 0x55,0x66 -> frame_err pulses once after the 20th accept; no push for the oversize frame; then 0x02,0x55,0x66 pushed; frame_cnt=1.
- Back-to-back: 3 frames driven with s_valid=1 continuously -> s_ready toggles per frame; the FIFO receives three correctly delimited frames in order; frame_cnt=3; busy low only during COLLECT/DROP... (COLLECT only).

Source files
------------

// File: rtl/fifo_frame_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_frame_writer_if                                                 |
// | Upstream valid/ready stream plus FIFO write port of the frame writer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fifo_frame_writer_if #(
    parameter int DWIDTH = 8
) ();
    logic              s_valid;
    logic [DWIDTH-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              push;
    logic [DWIDTH-1:0] din;
    logic              fifo_full;

    // slave is the frame writer's view; master is the surrounding environment
    modport slave  (input  s_valid, s_data, s_last, fifo_full,
                    output s_ready, push, din);
    modport master (output s_valid, s_data, s_last, fifo_full,
                    input  s_ready, push, din);
endinterface
`default_nettype wire

// File: rtl/fifo_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_frame_writer                                                    |
// | Buffers an upstream frame, then pushes a length header and payload   |
// | into the dual-clock FIFO write port.                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_frame_writer #(
    parameter int DWIDTH  = 8,
    parameter int MAX_LEN = 16
) (
    input  wire logic           wclk,
    input  wire logic           rstn,
    fifo_frame_writer_if.slave  bus,
    output logic                frame_done,
    output logic                frame_err,
    output logic [15:0]         frame_cnt,
    output logic                busy
);

    localparam int c_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    // One extra bit so the length register can hold MAX_LEN itself
    localparam int c_IW = $clog2(MAX_LEN) + 1;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(MAX_LEN - 1);
    localparam logic [c_IW-1:0] c_ONE      = c_IW'(1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DROP    = 2'd1,
        S_HDR     = 2'd2,
        S_PAYLOAD = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_IW-1:0]   r_wr_idx;
    logic [c_IW-1:0]   w_wr_idx_nxt;
    logic [c_IW-1:0]   r_rd_idx;
    logic [c_IW-1:0]   w_rd_idx_nxt;
    logic [c_IW-1:0]   r_len;
    logic [c_IW-1:0]   w_len_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_buf_we;
    logic              w_push;
    logic              w_s_ready;
    logic [DWIDTH-1:0] w_din;
    logic [DWIDTH-1:0] r_buf [MAX_LEN];
    logic              r_frame_done;
    logic              r_frame_err;
    logic [15:0]       r_frame_cnt;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_idx_nxt = r_wr_idx;
        w_rd_idx_nxt = r_rd_idx;
        w_len_nxt    = r_len;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_buf_we     = 1'b0;
        w_s_ready    = 1'b0;
        w_push       = 1'b0;
        w_din        = '0;
        case (r_state)
            S_COLLECT: begin
                w_s_ready = 1'b1;
                if (bus.s_valid) begin
                    w_buf_we = 1'b1;
                    if (bus.s_last) begin
                        w_len_nxt    = r_wr_idx + c_ONE;
                        w_wr_idx_nxt = '0;
                        w_state_nxt  = S_HDR;
                    end else if (r_wr_idx == c_LAST_IDX) begin
                        w_wr_idx_nxt = '0;
                        w_state_nxt  = S_DROP;
                    end else begin
                        w_wr_idx_nxt = r_wr_idx + c_ONE;
                    end
                end
            end
            S_DROP: begin
                w_s_ready = 1'b1;
                if (bus.s_valid && bus.s_last) begin
                    w_err_nxt    = 1'b1;
                    w_wr_idx_nxt = '0;
                    w_rd_idx_nxt = '0;
                    w_state_nxt  = S_COLLECT;
                end
            end
            S_HDR: begin
                w_push = ~bus.fifo_full;
                w_din  = DWIDTH'(r_len);
                if (w_push) begin
                    w_rd_idx_nxt = '0;
                    w_state_nxt  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                w_push = ~bus.fifo_full;
                w_din  = r_buf[r_rd_idx[c_AW-1:0]];
                if (w_push) begin
                    if (r_rd_idx == r_len - c_ONE) begin
                        w_done_nxt   = 1'b1;
                        w_rd_idx_nxt = '0;
                        w_wr_idx_nxt = '0;
                        w_state_nxt  = S_COLLECT;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + c_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_COLLECT;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_len        <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_idx     <= w_wr_idx_nxt;
            r_rd_idx     <= w_rd_idx_nxt;
            r_len        <= w_len_nxt;
            r_frame_done <= w_done_nxt;
            r_frame_err  <= w_err_nxt;
            r_frame_cnt  <= r_frame_cnt + {15'd0, w_done_nxt};
        end
    end

    // Frame storage needs no reset: it is always rewritten before being read
    always_ff @(posedge wclk) begin
        if (w_buf_we) begin
            r_buf[r_wr_idx[c_AW-1:0]] <= bus.s_data;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.push    = w_push;
    assign bus.din     = w_din;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;
    assign frame_cnt   = r_frame_cnt;
    assign busy        = (r_state != S_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_fifo_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_frame_writer                                                 |
// | Directed self-checking bench for fifo_frame_writer                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fifo_frame_writer;

    logic        wclk;
    logic        rstn;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic        busy;

    fifo_frame_writer_if #(.DWIDTH(8)) bus ();

    fifo_frame_writer #(.DWIDTH(8), .MAX_LEN(16)) dut (
        .wclk       (wclk),
        .rstn       (rstn),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pq[$];
    logic [7:0] eq[$];
    int         pq_base = 0;
    int         n_err = 0;
    int         n_done = 0;
    int         n_both = 0;
    int         n_push_full = 0;
    int         n_bad_busy = 0;
    logic       chk_busy = 1'b0;

    // Observes the FIFO write port and status pulses mid-cycle
    always @(negedge wclk) begin
        if (rstn) begin
            if (bus.push === 1'b1) pq.push_back(bus.din);
            if (frame_done === 1'b1) n_done++;
            if (frame_err === 1'b1) n_err++;
            if (frame_done === 1'b1 && frame_err === 1'b1) n_both++;
            if (bus.push === 1'b1 && bus.fifo_full === 1'b1) n_push_full++;
            if (chk_busy && busy === bus.s_ready) n_bad_busy++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag);
        check({tag, "_count"}, pq.size() - pq_base, eq.size());
        for (int i = 0; i < eq.size(); i++) begin
            if (pq_base + i < pq.size()) check(tag, {24'd0, pq[pq_base + i]}, {24'd0, eq[i]});
        end
        eq.delete();
        pq_base = pq.size();
    endtask

    task automatic do_reset();
        @(negedge wclk);
        rstn          = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.fifo_full = 1'b0;
        repeat (2) @(negedge wclk);
        rstn    = 1'b1;
        pq_base = pq.size();
    endtask

    // Presents one word and returns just after the edge that accepts it
    task automatic send(input logic [7:0] d, input logic l);
        int t = 0;
        @(negedge wclk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (bus.s_ready !== 1'b1 && t < 200) begin
            @(negedge wclk);
            t++;
        end
        check("send_timeout", {31'd0, (t < 200)}, 32'd1);
        @(posedge wclk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (frame_done !== 1'b1 && t < 100) begin
            @(negedge wclk);
            t++;
        end
        check({tag, "_done_timeout"}, {31'd0, (t < 100)}, 32'd1);
    endtask

    initial begin
        int e_base;
        rstn          = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = 8'h00;
        bus.s_last    = 1'b0;
        bus.fifo_full = 1'b0;

        // Reset state
        repeat (2) @(negedge wclk);
        check("rst_push", bus.push, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);
        rstn = 1'b1;
        @(negedge wclk);
        check("rst_sready", bus.s_ready, 1);

        // Reset during the second payload push of a 4-word frame
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
        @(negedge wclk);
        check("mr_hdr", bus.din, 8'h04);
        @(negedge wclk);
        check("mr_p0", bus.din, 8'h01);
        @(negedge wclk);
        check("mr_p1_push", bus.push, 1);
        check("mr_p1_din", bus.din, 8'h02);
        #1 rstn = 1'b0;
        #1;
        check("mr_push_low", bus.push, 0);
        check("mr_cnt", frame_cnt, 0);
        check("mr_busy", busy, 0);
        @(negedge wclk);
        rstn = 1'b1;
        pq_base = pq.size();
        #1;
        check("mr_sready", bus.s_ready, 1);
        send(8'hAA, 1);
        wait_done("mr");
        eq = '{8'h01, 8'hAA};
        check_q("mr_q");
        check("mr_cnt1", frame_cnt, 1);

        // Three-word frame, no backpressure: exact cycle timing
        do_reset();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
        @(negedge wclk);
        check("t2_hdr_push", bus.push, 1);
        check("t2_hdr_din", bus.din, 8'h03);
        check("t2_hdr_sready", bus.s_ready, 0);
        check("t2_busy", busy, 1);
        @(negedge wclk);
        check("t2_p0_push", bus.push, 1);
        check("t2_p0_din", bus.din, 8'h11);
        @(negedge wclk);
        check("t2_p1_push", bus.push, 1);
        check("t2_p1_din", bus.din, 8'h22);
        check("t2_p1_sready", bus.s_ready, 0);
        @(negedge wclk);
        check("t2_p2_push", bus.push, 1);
        check("t2_p2_din", bus.din, 8'h33);
        check("t2_p2_done", frame_done, 0);
        @(negedge wclk);
        check("t2_done", frame_done, 1);
        check("t2_push_off", bus.push, 0);
        check("t2_sready", bus.s_ready, 1);
        check("t2_cnt", frame_cnt, 1);
        check("t2_busy_off", busy, 0);
        eq = '{8'h03, 8'h11, 8'h22, 8'h33};
        check_q("t2_q");

        // Same frame with fifo_full stalls at the header and before 0x22
        do_reset();
        bus.fifo_full = 1'b1;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge wclk);
            check("t3_hstall_push", bus.push, 0);
            check("t3_hstall_din", bus.din, 8'h03);
        end
        @(posedge wclk);
        #1 bus.fifo_full = 1'b0;
        @(negedge wclk);
        check("t3_hdr_push", bus.push, 1);
        check("t3_hdr_din", bus.din, 8'h03);
        @(negedge wclk);
        check("t3_p0_din", bus.din, 8'h11);
        @(posedge wclk);
        #1 bus.fifo_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge wclk);
            check("t3_pstall_push", bus.push, 0);
            check("t3_pstall_din", bus.din, 8'h22);
        end
        @(posedge wclk);
        #1 bus.fifo_full = 1'b0;
        wait_done("t3");
        check("t3_cnt", frame_cnt, 1);
        eq = '{8'h03, 8'h11, 8'h22, 8'h33};
        check_q("t3_q");

        // Exactly MAX_LEN words is legal
        do_reset();
        e_base = n_err;
        for (int i = 0; i < 16; i++) send(8'(i), (i == 15));
        wait_done("t4");
        eq.push_back(8'h10);
        for (int i = 0; i < 16; i++) eq.push_back(8'(i));
        check_q("t4_q");
        check("t4_err", n_err - e_base, 0);
        check("t4_cnt", frame_cnt, 1);

        // Oversize frame is dropped, following frame goes through
        do_reset();
        e_base = n_err;
        for (int i = 0; i < 20; i++) send(8'(8'h80 + i), (i == 19));
        @(negedge wclk);
        check("t5_err_pulse", frame_err, 1);
        check("t5_err_push", bus.push, 0);
        check_q("t5_nopush");
        send(8'h55, 0); send(8'h66, 1);
        wait_done("t5");
        eq = '{8'h02, 8'h55, 8'h66};
        check_q("t5_q");
        check("t5_cnt", frame_cnt, 1);
        check("t5_err_once", n_err - e_base, 1);

        // Back-to-back frames with s_valid held high
        do_reset();
        chk_busy = 1'b1;
        send(8'hA1, 0); send(8'hA2, 1);
        send(8'hB1, 1);
        send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 1);
        wait_done("t6");
        @(negedge wclk);
        chk_busy = 1'b0;
        eq = '{8'h02, 8'hA1, 8'hA2, 8'h01, 8'hB1, 8'h03, 8'hC1, 8'hC2, 8'hC3};
        check_q("t6_q");
        check("t6_cnt", frame_cnt, 3);
        check("t6_busy", n_bad_busy, 0);

        check("push_while_full", n_push_full, 0);
        check("done_and_err", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
